// File: rtl/lms_ctr_oc_mem_pkg.sv
// Shared types and constants for the lms_ctr on-chip memory loader.
// Optional read-back checksum pass: define LMS_CTR_OC_MEM_VERIFY_EN.
package lms_ctr_oc_mem_pkg;

    // Loader command sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/lms_ctr_oc_mem_loader_if.sv
// Byte stream plus Avalon-MM bus bundle for the on-chip memory loader.
// master: the loader's view (stream sink, bus initiator).
// slave:  the environment's view (stream source, memory slave).
interface lms_ctr_oc_mem_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic              avm_read;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    modport master (
        input  s_data, s_valid, avm_waitrequest, avm_readdata,
        output s_ready, avm_address, avm_chipselect, avm_write, avm_read,
               avm_writedata, avm_byteenable
    );

    modport slave (
        output s_data, s_valid, avm_waitrequest, avm_readdata,
        input  s_ready, avm_address, avm_chipselect, avm_write, avm_read,
               avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/lms_ctr_oc_mem_packer.sv
// Packs stream bytes little-endian into a 32-bit word: byte 0 lands in [7:0].
// Raises word_ready after the fourth byte until the word is consumed.
module lms_ctr_oc_mem_packer
    import lms_ctr_oc_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        shift_en,
    input  logic        clear_ready,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        last_lane
);

    localparam int         IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]      lanes_q, lanes_d;
    logic             word_ready_q, word_ready_d;

    assign last_lane  = (byte_idx_q == IDX_LAST);
    assign word       = lanes_q;
    assign word_ready = word_ready_q;

    // Next lane contents, byte counter and ready flag
    always_comb begin
        byte_idx_d   = byte_idx_q;
        lanes_d      = lanes_q;
        word_ready_d = word_ready_q;
        if (clear_ready) begin
            word_ready_d = 1'b0;
        end
        if (restart) begin
            byte_idx_d   = '0;
            word_ready_d = 1'b0;
        end else if (shift_en) begin
            lanes_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
            byte_idx_d = byte_idx_q + 1'b1;
            if (last_lane) begin
                word_ready_d = 1'b1;
            end
        end
    end

    // Packer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_q   <= '0;
            lanes_q      <= '0;
            word_ready_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            lanes_q      <= lanes_d;
            word_ready_q <= word_ready_d;
        end
    end

endmodule

// File: rtl/lms_ctr_oc_mem_loader.sv
// Avalon-MM initiator that fills the lms_ctr on-chip memory from a byte
// stream. Words are written from a commanded base address for a commanded
// word count; the address wraps modulo 2^ADDR_W.
// Optional read-back checksum pass: define LMS_CTR_OC_MEM_VERIFY_EN.
module lms_ctr_oc_mem_loader
    import lms_ctr_oc_mem_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic                error,
    lms_ctr_oc_mem_loader_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic        start_ok;
    logic        wr_accept;
    logic        last_word;
    logic        fill_hs;
    logic [31:0] packed_word;
    logic        word_ready;
    logic        last_lane;

    assign fill_hs   = bus.s_ready & bus.s_valid;
    assign last_word = (count_q == CNT_ONE);

    lms_ctr_oc_mem_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .restart     (start_ok),
        .shift_en    (fill_hs),
        .clear_ready (wr_accept),
        .byte_in     (bus.s_data),
        .word        (packed_word),
        .word_ready  (word_ready),
        .last_lane   (last_lane)
    );

`ifdef LMS_CTR_OC_MEM_VERIFY_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic              rd_valid_q, rd_valid_d;
    logic [31:0]       sum_wr_q, sum_wr_d;
    logic [31:0]       sum_rd_q, sum_rd_d;
    logic              error_q, error_d;
    logic              rd_accept;

    assign rd_accept = bus.avm_read & ~bus.avm_waitrequest;
    assign error     = error_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.avm_readdata;
    assign error        = 1'b0;
`endif

    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = packed_word;
    assign bus.avm_byteenable = BYTEENABLE_ALL;
    assign bus.avm_chipselect = bus.avm_write | bus.avm_read;

    // Command FSM: next state, address/count pointers and bus/stream strobes
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        start_ok      = 1'b0;
        wr_accept     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        bus.s_ready   = 1'b0;
        bus.avm_write = 1'b0;
        bus.avm_read  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    addr_d   = base_addr;
                    count_d  = word_count;
                    state_d  = (word_count == CNT_ZERO) ? DONE : FILL;
                end
            end
            FILL: begin
                busy        = 1'b1;
                bus.s_ready = 1'b1;
                if (bus.s_valid && last_lane) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy          = 1'b1;
                bus.avm_write = word_ready;
                if (word_ready && !bus.avm_waitrequest) begin
                    wr_accept = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
                    count_d   = count_q - CNT_ONE;
                    if (last_word) begin
`ifdef LMS_CTR_OC_MEM_VERIFY_EN
                        addr_d  = base_q;
                        state_d = VERIFY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = FILL;
                    end
                end
            end
`ifdef LMS_CTR_OC_MEM_VERIFY_EN
            VERIFY: begin
                busy = 1'b1;
                if (rd_left_q != CNT_ZERO) begin
                    bus.avm_read = 1'b1;
                    if (!bus.avm_waitrequest) begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, address pointer and remaining-word count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

`ifdef LMS_CTR_OC_MEM_VERIFY_EN
    // Checksums, read bookkeeping and the final read-back compare
    always_comb begin
        base_d     = base_q;
        wc_d       = wc_q;
        rd_left_d  = rd_left_q;
        rd_valid_d = 1'b0;
        sum_wr_d   = sum_wr_q;
        sum_rd_d   = sum_rd_q;
        error_d    = error_q;
        if (rd_valid_q) begin
            sum_rd_d = sum_rd_q + bus.avm_readdata;
        end
        if (start_ok) begin
            base_d    = base_addr;
            wc_d      = word_count;
            rd_left_d = '0;
            sum_wr_d  = '0;
            sum_rd_d  = '0;
            error_d   = 1'b0;
        end
        if (wr_accept) begin
            sum_wr_d = sum_wr_q + packed_word;
            if (last_word) begin
                rd_left_d = wc_q;
            end
        end
        if (rd_accept) begin
            rd_left_d  = rd_left_q - CNT_ONE;
            rd_valid_d = 1'b1;
        end
        if (state_q == VERIFY && rd_left_q == CNT_ZERO) begin
            error_d = (sum_rd_d != sum_wr_q);
        end
    end

    // Verify-pass registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q     <= '0;
            wc_q       <= '0;
            rd_left_q  <= '0;
            rd_valid_q <= 1'b0;
            sum_wr_q   <= '0;
            sum_rd_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            wc_q       <= wc_d;
            rd_left_q  <= rd_left_d;
            rd_valid_q <= rd_valid_d;
            sum_wr_q   <= sum_wr_d;
            sum_rd_q   <= sum_rd_d;
            error_q    <= error_d;
        end
    end
`endif

endmodule

// File: tb/tb_lms_ctr_oc_mem_loader.sv
// Scoreboard bench for lms_ctr_oc_mem_loader. Commands are modelled as
// plain word lists; expected writes and completions are queued at issue
// time and checked by a monitor that also plays the on-chip memory.
module tb_lms_ctr_oc_mem_loader;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LMS_CTR_OC_MEM_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy, done, error;

    lms_ctr_oc_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    lms_ctr_oc_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic err;
        int   writes;
        int   reads;
    } done_t;

    wr_t   exp_wr_q[$];
    done_t exp_done_q[$];

    int checks = 0;
    int failures = 0;
    int writes_seen = 0;
    int reads_seen = 0;
    int done_count = 0;
    int stall_cycles = 0;
    bit sready_seen = 0;
    bit first_read = 0;
    bit rand_stall = 0;
    bit hold_arm = 0;
    int hold_left = 0;
    logic [31:0] rd_mask = '0;
    logic [31:0] rd_pipe = '0;
    bit rd_pipe_valid = 0;
    bit [31:0] mem [DEPTH];

    bit                stall_prev = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory read data with a one-cycle latency after each accepted read
    always @(posedge clk) begin
        #1;
        bus.avm_readdata = rd_pipe_valid ? rd_pipe : $urandom;
        rd_pipe_valid    = 0;
    end

    // Slave stall generator: a directed 3-cycle hold or random stalls
    always @(posedge clk) begin
        #2;
        if (hold_arm && bus.avm_write) begin
            hold_left = 3;
            hold_arm  = 0;
        end
        if (hold_left > 0) begin
            bus.avm_waitrequest = 1'b1;
            hold_left--;
        end else begin
            bus.avm_waitrequest = rand_stall && ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: memory model, write scoreboard, stall stability and completion
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.s_ready) sready_seen = 1;
            if (bus.avm_write || bus.avm_read || bus.avm_chipselect) begin
                checkOutput("chipselect", bus.avm_chipselect, bus.avm_write | bus.avm_read);
                checkOutput("rd_wr_overlap", bus.avm_write & bus.avm_read, 0);
            end
            if (stall_prev) begin
                checkOutput("stall_write", bus.avm_write, 1);
                checkOutput("stall_addr", bus.avm_address, prev_addr);
                checkOutput("stall_data", bus.avm_writedata, prev_data);
            end
            stall_prev = bus.avm_write && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            prev_data  = bus.avm_writedata;
            if (stall_prev) stall_cycles++;
            if (bus.avm_write && !bus.avm_waitrequest) begin
                writes_seen++;
                mem[bus.avm_address] = bus.avm_writedata;
                checkOutput("write_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    checkOutput("wr_addr", bus.avm_address, e.addr);
                    checkOutput("wr_data", bus.avm_writedata, e.data);
                end
            end
            if (bus.avm_read && !bus.avm_waitrequest) begin
                reads_seen++;
                rd_pipe       = mem[bus.avm_address] ^ (first_read ? rd_mask : 32'h0);
                rd_pipe_valid = 1;
                first_read    = 0;
            end
            if (done) begin
                done_count++;
                checkOutput("done_expected", exp_done_q.size() != 0, 1);
                checkOutput("busy_in_done", busy, 0);
                if (exp_done_q.size() != 0) begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    checkOutput("done_error", error, d.err);
                    checkOutput("write_count", writes_seen, d.writes);
                    checkOutput("read_count", reads_seen, d.reads);
                end
                writes_seen = 0;
                reads_seen  = 0;
            end
        end
    end

    task automatic sendBytes(input byte unsigned b[$], input int n, input bit gaps);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 4000) begin
            @(posedge clk);
            #2;
            bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.s_data  = b[idx];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) idx++;
            guard++;
        end
        checkOutput("bytes_accepted", idx, n);
        @(posedge clk);
        #2;
        bus.s_valid = 1'b0;
    endtask

    task automatic issueStart(input logic [ADDR_W-1:0] base, input int wc);
        @(posedge clk);
        #2;
        start      = 1'b1;
        base_addr  = base;
        word_count = (ADDR_W+1)'(wc);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Run one command: build the model, queue expectations, drive, wait for done
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int wc, input logic [31:0] mask,
                                 input bit seq, input bit gaps, input bit stalls, input bit hold);
        byte unsigned b[$];
        logic [31:0]  sum_wr = 0;
        logic [31:0]  sum_rd = 0;
        int           start_done;
        int           cyc = 0;
        done_t        d;
        for (int i = 0; i < 4 * wc; i++) b.push_back(seq ? 8'(i + 1) : 8'($urandom));
        for (int i = 0; i < wc; i++) begin
            wr_t w;
            w.data = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            w.addr = ADDR_W'((int'(base) + i) % DEPTH);
            exp_wr_q.push_back(w);
            sum_wr += w.data;
            sum_rd += (i == 0) ? (w.data ^ mask) : w.data;
        end
        d.err    = VERIFY_ON && (sum_rd != sum_wr);
        d.writes = wc;
        d.reads  = VERIFY_ON ? wc : 0;
        exp_done_q.push_back(d);
        rd_mask      = mask;
        first_read   = 1;
        rand_stall   = stalls;
        hold_arm     = hold;
        stall_cycles = 0;
        sready_seen  = 0;
        start_done   = done_count;
        issueStart(base, wc);
        @(negedge clk);
        checkOutput("cycle1_error_cleared", error, 0);
        if (wc == 0) begin
            checkOutput("zero_done_cycle1", done, 1);
            checkOutput("zero_busy", busy, 0);
        end else begin
            checkOutput("cycle1_busy", busy, 1);
            checkOutput("cycle1_s_ready", bus.s_ready, 1);
            sendBytes(b, 4 * wc, gaps);
        end
        while (done_count == start_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_in_budget", done_count != start_done, 1);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("error_held", error, d.err);
        if (wc == 0) checkOutput("zero_no_s_ready", sready_seen, 0);
        if (hold) checkOutput("hold_stall_cycles", stall_cycles, 3);
        rand_stall = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_s_ready"}, bus.s_ready, 0);
        checkOutput({tag, "_write"}, bus.avm_write, 0);
        checkOutput({tag, "_read"}, bus.avm_read, 0);
        checkOutput({tag, "_cs"}, bus.avm_chipselect, 0);
        checkOutput({tag, "_addr"}, bus.avm_address, 0);
        checkOutput({tag, "_wdata"}, bus.avm_writedata, 0);
        checkOutput({tag, "_be"}, bus.avm_byteenable, 4'hF);
    endtask

    initial begin
        byte unsigned part[$];
        reset               = 1'b1;
        start               = 1'b0;
        base_addr           = '0;
        word_count          = '0;
        bus.s_valid         = 1'b0;
        bus.s_data          = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = '0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;

        $display("[TB] directed: two words at 0x0010");
        applyStimulus(13'h0010, 2, 32'h0, 1, 0, 0, 0);
        $display("[TB] directed: 3-cycle waitrequest on first write");
        applyStimulus(13'h0010, 2, 32'h0, 1, 0, 0, 1);
        $display("[TB] directed: address wrap at top");
        applyStimulus(13'h1FFF, 2, 32'h0, 0, 0, 0, 0);
        $display("[TB] directed: zero word count");
        applyStimulus(13'h0123, 0, 32'h0, 0, 0, 0, 0);
        $display("[TB] directed: corrupted first read-back word");
        applyStimulus(13'h0010, 2, 32'h1, 1, 0, 0, 0);
        applyStimulus(13'h0200, 1, 32'h0, 0, 0, 0, 0);

        $display("[TB] directed: reset after two bytes");
        for (int i = 0; i < 2; i++) part.push_back(8'($urandom));
        issueStart(13'h0040, 1);
        sendBytes(part, 2, 0);
        reset = 1'b1;
        exp_wr_q.delete();
        exp_done_q.delete();
        writes_seen = 0;
        reads_seen  = 0;
        stall_prev  = 0;
        @(negedge clk);
        checkResetValues("abort");
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_write", writes_seen, 0);
        applyStimulus(13'h0040, 1, 32'h0, 0, 0, 0, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 10; n++) begin
            logic [ADDR_W-1:0] base;
            logic [31:0]       mask;
            base = (n % 2 == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                : ADDR_W'(DEPTH - 1 - $urandom_range(0, 3));
            mask = ($urandom_range(0, 2) == 0) ? ($urandom | 32'h1) : 32'h0;
            applyStimulus(base, $urandom_range(1, 6), mask, 0, 1, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lms_ctr_oc_mem_loader.md
# lms_ctr_oc_mem_loader

Avalon-MM initiator that fills the lms_ctr on-chip memory from a byte stream, such as boot image bytes from the configuration flash reader. It sits beside the on-chip memory inside lms_ctr and drives that memory's 32-bit word-addressed slave port. Bytes are packed little-endian into words and written from a commanded base address for a commanded word count. An optional read-back pass checks the written region with a checksum.

## Interface

Parameters:
- ADDR_W, 13, word address width; the target depth is 2^ADDR_W words.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled on start.
- word_count  in  ADDR_W+1  number of words to write, 0 to 2^ADDR_W; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  verify mismatch; held until the next accepted start.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte.
- avm_address  out  ADDR_W  word address.
- avm_chipselect  out  1  high whenever avm_write or avm_read is high.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_writedata  out  32  packed word.
- avm_byteenable  out  4  always 4'hF.
- avm_waitrequest  in  1  slave stall; tie to 0 for the on-chip memory.
- avm_readdata  in  32  read data; fixed read latency of 1 cycle.

## Operation

States: IDLE, FILL, WRITE, VERIFY, DONE.

- IDLE
  - start latches base_addr and word_count, clears sum_wr, sum_rd and error, and goes to FILL.
  - If word_count is 0, go to DONE instead.
  - start in any other state is ignored.
- FILL
  - s_ready=1.
  - Each handshake (s_valid & s_ready) shifts the byte into lane byte_idx, 0 to 3; byte 0 lands in [7:0].
  - On the 4th byte, go to WRITE.
- WRITE
  - avm_write=1, with the address at the current pointer and the packed word on avm_writedata.
  - Outputs stay stable while avm_waitrequest=1.
  - On acceptance:
    - add the word to sum_wr, modulo 2^32;
    - increment the address modulo 2^ADDR_W, so the pointer wraps past the top;
    - decrement the remaining count.
  - Next state: FILL if words remain; otherwise VERIFY (macro on) or DONE.
- VERIFY
  - The address is reloaded with base_addr.
  - avm_read=1 each cycle until word_count reads have been accepted; the address increments per accepted read.
  - Each accepted read's avm_readdata is added to sum_rd in the following cycle.
  - One cycle after the last read, compare: error = (sum_rd != sum_wr). Then go to DONE.
- DONE
  - done=1 for one cycle, then IDLE.
  - busy=0 in DONE.
- Stream handling
  - Bytes offered in IDLE, WRITE, VERIFY or DONE are not accepted (s_ready=0).
  - There are no trailing partial words: a command always consumes exactly 4*word_count bytes.
- Reset
  - Reset asserted mid-command aborts it immediately. No further bus cycles are issued.

## Timing

- Reset values: all outputs 0 except avm_byteenable=4'hF; the FSM is in IDLE.
- start accepted at cycle 0: busy=1 and s_ready=1 from cycle 1.
- Byte throughput: 1 byte per cycle while s_valid is held. Each word costs 4 FILL cycles plus at least 1 WRITE cycle, so a full-rate stream needs a 5-cycle minimum per word.
- word_count=0: done in cycle 1, busy stays 0, and there is no bus activity.
- Verify: N read cycles plus 1 compare cycle, then done.
- error is valid in the done cycle and afterwards.
- Reads and writes are never asserted together.

## Configuration

- LMS_CTR_OC_MEM_VERIFY_EN
  - Defined: VERIFY state, both checksum accumulators and the error output logic are compiled in.
  - Undefined: WRITE goes straight to DONE after the last word; avm_read and error are constant 0; no sum registers.

## Structure

- Package lms_ctr_oc_mem_pkg holds:
  - the state enum;
  - the constant BYTES_PER_WORD=4;
  - the constant BYTEENABLE_ALL=4'hF.
- Sub-module lms_ctr_oc_mem_packer contains the byte counter, the lane shift register, and the word-ready flag with its clear.
- The FSM, address and count registers, and checksum logic stay in the top module.

## Test plan

- base_addr=0x0010, word_count=2, bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201 @0x0010 and 0x08070605 @0x0011; done once; error=0.
- avm_waitrequest held high 3 cycles during the first write -> avm_address, avm_writedata and avm_write stable all 3 cycles; exactly 2 writes total.
- base_addr=0x1FFF, word_count=2 -> writes @0x1FFF then @0x0000.
- word_count=0 -> done in cycle 1; no avm_write or avm_read; s_ready never 1.
- VERIFY_EN, bench returns 0x04030200 for the first read -> error=1 in the done cycle; the next start clears error.
- reset asserted after 2 of 4 bytes -> all outputs at reset values, no write issued; a following command completes normally.
